// File: rtl/rays_soc_pkg.sv
// Shared SoC definitions: IO page decode, MMIO register offsets, STATUS bit
// positions and the UART serializer state encoding.
package rays_soc_pkg;

  localparam int IO_PAGE_BIT = 22;

  localparam logic [3:0] IO_LEDS    = 4'd0;
  localparam logic [3:0] IO_UART_TX = 4'd1;
  localparam logic [3:0] IO_STATUS  = 4'd2;
  localparam logic [3:0] IO_CYCLES  = 4'd3;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: small byte FIFO feeding an 8N1 serializer whose output
// bit is registered so the pin never glitches.
module uart_tx
  import rays_soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       push_accept,
  output logic       busy,
  output logic       full,
  output logic       tx_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  ser_state_e    r_state;
  ser_state_e    w_state_d;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_d;
  logic [CW-1:0] r_baud;
  logic [CW-1:0] w_baud_d;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_d;
  logic          r_tx;
  logic          w_tx_d;
  logic          w_pop;
  logic          w_baud_end;

  assign w_baud_end  = (r_baud == BAUD_LAST);
  assign full        = (r_count == DEPTH_C);
  assign push_accept = push_valid & (~full | w_pop);
  assign busy        = (r_state != SER_IDLE) | (r_count != '0);
  assign tx_o        = r_tx;

  always_ff @(posedge clk_i) begin
    if (push_accept) r_fifo[r_wptr] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_accept) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)       r_rptr <= r_rptr + PTR_ONE;
      case ({push_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= SER_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_tx    <= w_tx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    r_shift <= w_shift_d;
  end

  // r_tx is loaded with the level of the state being entered, so the pin
  // changes exactly on the edge that changes state.
  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_baud_d  = r_baud;
    w_bit_d   = r_bit;
    w_tx_d    = r_tx;
    w_pop     = 1'b0;
    case (r_state)
      SER_IDLE: begin
        w_tx_d = 1'b1;
        if (r_count != '0) begin
          w_pop     = 1'b1;
          w_shift_d = r_fifo[r_rptr];
          w_state_d = SER_START;
          w_baud_d  = '0;
          w_tx_d    = 1'b0;
        end
      end
      SER_START: begin
        if (w_baud_end) begin
          w_state_d = SER_DATA;
          w_baud_d  = '0;
          w_bit_d   = '0;
          w_tx_d    = r_shift[0];
        end else begin
          w_baud_d = r_baud + BAUD_ONE;
        end
      end
      SER_DATA: begin
        if (w_baud_end) begin
          w_baud_d = '0;
          if (r_bit == 3'd7) begin
            w_state_d = SER_STOP;
            w_tx_d    = 1'b1;
          end else begin
            w_bit_d   = r_bit + 3'd1;
            w_shift_d = {1'b0, r_shift[7:1]};
            w_tx_d    = r_shift[1];
          end
        end else begin
          w_baud_d = r_baud + BAUD_ONE;
        end
      end
      SER_STOP: begin
        if (w_baud_end) begin
          w_state_d = SER_IDLE;
          w_baud_d  = '0;
          w_tx_d    = 1'b1;
        end else begin
          w_baud_d = r_baud + BAUD_ONE;
        end
      end
      default: begin
        w_state_d = SER_IDLE;
        w_tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the core's memory port: word RAM plus an MMIO
// page with LEDs, UART transmitter, status and a free-running cycle counter.
module mem_responder
  import rays_soc_pkg::*;
#(
  parameter int    RAM_WORDS    = 1536,
  parameter string INIT_FILE    = "",
  parameter int    LED_W        = 5,
  parameter int    CLKS_PER_BIT = 104,
  parameter int    FIFO_DEPTH   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      mem_addr_i,
  input  logic             mem_rstrb_i,
  output logic [31:0]      mem_rdata_o,
  input  logic [3:0]       mem_wmask_i,
  input  logic [31:0]      mem_wdata_i,
  output logic [LED_W-1:0] leds_o,
  output logic             uart_tx_o
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0]      r_ram [RAM_WORDS];
  logic [LED_W-1:0] r_leds;
  logic [31:0]      r_cycles;
  logic             r_overflow;

  logic [AW-1:0] w_ram_idx;
  logic          w_is_io;
  logic [3:0]    w_io_off;
  logic          w_wr;
  logic          w_ram_we;
  logic          w_io_we;
  logic          w_push;
  logic          w_push_accept;
  logic          w_tx_busy;
  logic          w_fifo_full;
  logic          w_ovf_clear;
  logic [31:0]   w_io_rdata;

  // RAM is not a power of two deep, so the word index wraps by true modulo.
  assign w_ram_idx   = AW'({2'b00, mem_addr_i[31:2]} % RAM_WORDS);
  assign w_is_io     = mem_addr_i[IO_PAGE_BIT];
  assign w_io_off    = mem_addr_i[5:2];
  assign w_wr        = |mem_wmask_i;
  assign w_ram_we    = w_wr & ~w_is_io;
  assign w_io_we     = w_wr & w_is_io;
  assign w_push      = w_io_we & mem_wmask_i[0] & (w_io_off == IO_UART_TX);
  assign w_ovf_clear = w_io_we & mem_wmask_i[0] & (w_io_off == IO_STATUS) & mem_wdata_i[2];

  always_ff @(posedge clk_i) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask_i[b]) r_ram[w_ram_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_leds     <= '0;
      r_cycles   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_io_we && mem_wmask_i[0] && (w_io_off == IO_LEDS)) r_leds <= mem_wdata_i[LED_W-1:0];
      // A dropped byte in the same cycle as a clear keeps the flag set.
      if (w_push && !w_push_accept) r_overflow <= 1'b1;
      else if (w_ovf_clear)         r_overflow <= 1'b0;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_uart_tx (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_valid (w_push),
    .push_data  (mem_wdata_i[7:0]),
    .push_accept(w_push_accept),
    .busy       (w_tx_busy),
    .full       (w_fifo_full),
    .tx_o       (uart_tx_o)
  );

  always_comb begin
    w_io_rdata = '0;
    case (w_io_off)
      IO_LEDS:   w_io_rdata = 32'(r_leds);
      IO_STATUS: begin
        w_io_rdata[STAT_BUSY_BIT] = w_tx_busy;
        w_io_rdata[STAT_FULL_BIT] = w_fifo_full;
        w_io_rdata[STAT_OVF_BIT]  = r_overflow;
      end
      IO_CYCLES: w_io_rdata = r_cycles;
      default:   w_io_rdata = '0;
    endcase
  end

  // Combinational read: a same-cycle write is seen only after the edge.
  assign mem_rdata_o = !mem_rstrb_i ? 32'd0 : (w_is_io ? w_io_rdata : r_ram[w_ram_idx]);
  assign leds_o      = r_leds;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM/IO vector table, then hand-written
// UART frame, FIFO overflow, mid-frame reset and counter wrap sequences.
module tb_mem_responder;

  localparam int          CPB = 4;
  localparam logic [31:0] IOB = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [4:0]  leds;
  logic        uart_tx;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .RAM_WORDS   (1536),
    .INIT_FILE   (""),
    .LED_W       (5),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .mem_addr_i (mem_addr),
    .mem_rstrb_i(mem_rstrb),
    .mem_rdata_o(mem_rdata),
    .mem_wmask_i(mem_wmask),
    .mem_wdata_i(mem_wdata),
    .leds_o     (leds),
    .uart_tx_o  (uart_tx)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic r, input logic [3:0] m, input logic [31:0] d);
    mem_addr  = a;
    mem_rstrb = r;
    mem_wmask = m;
    mem_wdata = d;
  endtask

  task automatic bus_op(input logic [31:0] a, input logic r, input logic [3:0] m,
                        input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    drive(a, r, m, d);
    #1 rd = mem_rdata;
    @(posedge clk);
    #1 drive(32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int waited;
    waited = 0;
    ok = 1'b1;
    b  = 8'h00;
    @(negedge clk);
    while (uart_tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (uart_tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (2) @(negedge clk);
    if (uart_tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (CPB) @(negedge clk);
    if (uart_tx !== 1'b1) ok = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] c1;
    logic [39:0] got;
    logic [39:0] expv;
    logic [7:0]  fbyte;
    logic        flag;

    rst_ni = 1'b0;
    drive(32'h0, 1'b0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rst_leds", 64'(leds), 64'h0);
    chk("rst_tx", 64'(uart_tx), 64'h1);
    drive(IOB + 32'h8, 1'b1, 4'h0, 32'h0);
    #1 chk("rst_status", 64'(mem_rdata), 64'h0);
    drive(IOB + 32'hC, 1'b1, 4'h0, 32'h0);
    #1 chk("rst_cycles", 64'(mem_rdata), 64'h0);
    drive(32'h0, 1'b0, 4'h0, 32'h0);

    vecs.push_back('{"ram_full_wr",  32'h10,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{"ram_rd_full",  32'h10,        1'b1, 4'h0, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{"ram_byte_wr",  32'h10,        1'b0, 4'h4, 32'h00AA0000, 32'h0});
    vecs.push_back('{"ram_rd_byte",  32'h10,        1'b1, 4'h0, 32'h0,        32'hDEAABEEF});
    vecs.push_back('{"rstrb_low",    32'h10,        1'b0, 4'h0, 32'h0,        32'h0});
    vecs.push_back('{"alias_wr",     32'h1800,      1'b0, 4'hF, 32'h12345678, 32'h0});
    vecs.push_back('{"alias_rd",     32'h0,         1'b1, 4'h0, 32'h0,        32'h12345678});
    vecs.push_back('{"rd_during_wr", 32'h1800,      1'b1, 4'hF, 32'hCAFEF00D, 32'h12345678});
    vecs.push_back('{"rd_after_wr",  32'h0,         1'b1, 4'h0, 32'h0,        32'hCAFEF00D});
    vecs.push_back('{"ram_1031_wr",  32'h101C,      1'b0, 4'hF, 32'h55AA55AA, 32'h0});
    vecs.push_back('{"led_wr",       IOB,           1'b0, 4'h1, 32'hFFFFFF2A, 32'h0});
    vecs.push_back('{"led_rd",       IOB,           1'b1, 4'h0, 32'h0,        32'h0000000A});
    vecs.push_back('{"led_lane1_wr", IOB,           1'b0, 4'h2, 32'h0000FF00, 32'h0});
    vecs.push_back('{"led_rd_keep",  IOB,           1'b1, 4'h0, 32'h0,        32'h0000000A});
    vecs.push_back('{"led_wr_1f",    IOB,           1'b0, 4'h1, 32'h0000001F, 32'h0});
    vecs.push_back('{"led_rd_1f",    IOB,           1'b1, 4'h0, 32'h0,        32'h0000001F});
    vecs.push_back('{"off7_wr",      IOB + 32'h1C,  1'b0, 4'hF, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{"off7_rd",      IOB + 32'h1C,  1'b1, 4'h0, 32'h0,        32'h0});
    vecs.push_back('{"uart_rd",      IOB + 32'h4,   1'b1, 4'h0, 32'h0,        32'h0});
    vecs.push_back('{"status_idle",  IOB + 32'h8,   1'b1, 4'h0, 32'h0,        32'h0});
    vecs.push_back('{"ram_1031_rd",  32'h101C,      1'b1, 4'h0, 32'h0,        32'h55AA55AA});
    vecs.push_back('{"ram_10_keep",  32'h10,        1'b1, 4'h0, 32'h0,        32'hDEAABEEF});

    foreach (vecs[i]) begin
      bus_op(vecs[i].addr, vecs[i].rstrb, vecs[i].wmask, vecs[i].wdata, rd);
      chk(vecs[i].name, 64'(rd), 64'(vecs[i].exp));
    end
    chk("leds_pin", 64'(leds), 64'h1F);

    bus_op(IOB + 32'hC, 1'b1, 4'h0, 32'h0, c1);
    bus_op(IOB + 32'hC, 1'b1, 4'h0, 32'h0, rd);
    chk("cycles_step", 64'(rd - c1), 64'h1);

    // Single frame 0xA5, sampled cycle by cycle while STATUS is held on the bus
    fbyte = 8'hA5;
    bus_op(IOB + 32'h4, 1'b0, 4'h1, 32'(fbyte), rd);
    drive(IOB + 32'h8, 1'b1, 4'h0, 32'h0);
    @(negedge clk);
    flag = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int p;
      @(negedge clk);
      got[k] = uart_tx;
      if (mem_rdata[0] !== 1'b1) flag = 1'b0;
      p = k / CPB;
      expv[k] = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : fbyte[p-1];
    end
    drive(32'h0, 1'b0, 4'h0, 32'h0);
    chk("frame_a5", 64'(got), 64'(expv));
    chk("busy_in_frame", 64'(flag), 64'h1);
    bus_op(IOB + 32'h8, 1'b1, 4'h0, 32'h0, rd);
    chk("status_after_frame", 64'(rd), 64'h0);

    // Six back-to-back pushes into a four-entry FIFO
    fork
      begin
        logic [7:0] b;
        logic       ok;
        for (int j = 0; j < 5; j++) begin
          rx_byte(b, ok);
          chk("rx_frame_ok", 64'(ok), 64'h1);
          chk("rx_byte", 64'(b), 64'(8'(17 * (j + 1))));
        end
      end
      begin
        logic [31:0] r2;
        for (int j = 0; j < 6; j++) bus_op(IOB + 32'h4, 1'b0, 4'h1, 32'(8'(17 * (j + 1))), r2);
        bus_op(IOB + 32'h8, 1'b1, 4'h0, 32'h0, r2);
        chk("status_ovf_full", 64'(r2), 64'h7);
        bus_op(IOB + 32'h8, 1'b0, 4'h1, 32'h4, r2);
        bus_op(IOB + 32'h8, 1'b1, 4'h0, 32'h0, r2);
        chk("status_ovf_clr", 64'(r2), 64'h3);
      end
    join
    flag = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) flag = 1'b0;
    end
    chk("no_sixth_frame", 64'(flag), 64'h1);
    bus_op(IOB + 32'h8, 1'b1, 4'h0, 32'h0, rd);
    chk("status_drained", 64'(rd), 64'h0);

    // Reset while the serializer is in the DATA state
    bus_op(IOB + 32'h4, 1'b0, 4'h1, 32'h00, rd);
    repeat (12) @(negedge clk);
    chk("tx_mid_frame", 64'(uart_tx), 64'h0);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rst_mid_tx", 64'(uart_tx), 64'h1);
    chk("rst_mid_leds", 64'(leds), 64'h0);
    drive(IOB + 32'h8, 1'b1, 4'h0, 32'h0);
    #1 chk("rst_mid_status", 64'(mem_rdata), 64'h0);
    drive(IOB + 32'hC, 1'b1, 4'h0, 32'h0);
    #1 chk("rst_mid_cycles", 64'(mem_rdata), 64'h0);
    drive(32'h0, 1'b0, 4'h0, 32'h0);
    flag = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) flag = 1'b0;
    end
    chk("tx_idle_after_rst", 64'(flag), 64'h1);
    bus_op(32'h10, 1'b1, 4'h0, 32'h0, rd);
    chk("ram_retained_10", 64'(rd), 64'hDEAABEEF);
    bus_op(32'h0, 1'b1, 4'h0, 32'h0, rd);
    chk("ram_retained_0", 64'(rd), 64'hCAFEF00D);

    // Counter wrap
    @(negedge clk);
    force dut.r_cycles = 32'hFFFF_FFFE;
    #1 release dut.r_cycles;
    bus_op(IOB + 32'hC, 1'b1, 4'h0, 32'h0, rd);
    chk("cycles_max", 64'(rd), 64'hFFFFFFFF);
    bus_op(IOB + 32'hC, 1'b1, 4'h0, 32'h0, rd);
    chk("cycles_wrap", 64'(rd), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
